// File: rtl/param_bus_cpu.sv
// Multi-cycle bus CPU: fetch/decode control FSM, register file, A/G accumulator
// ALU path and program counter, parametrised on data, register and opcode widths.
module param_bus_cpu #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 6,
  parameter int OP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      instr_req,
  output logic [PC_W-1:0]           instr_addr,
  input  logic                      instr_valid,
  input  logic [OP_W+2*REG_AW-1:0]  instr_data,
  input  logic [DATA_W-1:0]         imm_data,
  output logic                      done,
  output logic                      halted,
  output logic [PC_W-1:0]           pc,
  output logic                      flag_z,
  output logic                      flag_c,
  input  logic [REG_AW-1:0]         dbg_sel,
  output logic [DATA_W-1:0]         dbg_data
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_ALU_G  = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_B    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BL   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BXLR = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

  localparam int LR = NREG - 1;

  logic [2:0]        state;
  logic [OP_W-1:0]   ir_op;
  logic [REG_AW-1:0] ir_rx;
  logic [REG_AW-1:0] ir_ry;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic              carry;
  logic [DATA_W:0]   alu_res;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;

  // Handshake: a fetch is accepted on a rising edge where instr_req && instr_valid;
  // instr_req is held low while reset is asserted and high only in FETCH.
  assign instr_req  = (state == S_FETCH) && rst;
  assign instr_addr = pc;
  assign pc_inc     = pc + PC_W'(1);
  assign target     = {ir_rx, ir_ry};
  assign dbg_data   = regs[dbg_sel];

  // Top bit of the widened subtraction is the unsigned borrow (A < R[ry]).
  always_comb begin
    alu_res = {1'b0, a ^ regs[ir_ry]};
    case (ir_op)
      OP_ADD:  alu_res = {1'b0, a} + {1'b0, regs[ir_ry]};
      OP_SUB:  alu_res = {1'b0, a} - {1'b0, regs[ir_ry]};
      default: alu_res = {1'b0, a ^ regs[ir_ry]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir_op  <= '0;
      ir_rx  <= '0;
      ir_ry  <= '0;
      a      <= '0;
      g      <= '0;
      carry  <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      done   <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            {ir_op, ir_rx, ir_ry} <= instr_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_FETCH;
          done  <= 1'b1;
          pc    <= pc_inc;
          case (ir_op)
            OP_LOAD: regs[ir_rx] <= imm_data;
            OP_MOV:  regs[ir_rx] <= regs[ir_ry];
            OP_ADD, OP_SUB, OP_XOR: begin
              // A is staged as the ALU op is dispatched so it retires 3 edges after fetch.
              a     <= regs[ir_rx];
              state <= S_ALU_G;
              done  <= 1'b0;
              pc    <= pc;
            end
            OP_B:    pc <= target;
            OP_BZ:   pc <= flag_z ? target : pc_inc;
            OP_BL: begin
              regs[LR] <= {{(DATA_W-PC_W){1'b0}}, pc_inc};
              pc       <= target;
            end
            OP_BXLR: pc <= regs[LR][PC_W-1:0];
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        S_ALU_G: begin
          g     <= alu_res[DATA_W-1:0];
          carry <= (ir_op == OP_XOR) ? 1'b0 : alu_res[DATA_W];
          state <= S_WRITE;
        end
        S_WRITE: begin
          regs[ir_rx] <= g;
          flag_z      <= (g == '0);
          flag_c      <= carry;
          pc          <= pc_inc;
          done        <= 1'b1;
          state       <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
